// File: rtl/fetch_control_unit.sv
// fetch_control_unit: drives PC enable/load/NOP-insert for the fetch stage (boot, flush, interrupt entry).
// Optional interrupt support is enabled by defining FETCH_CTRL_INT_EN.
`default_nettype none

module fetch_control_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0020,
  parameter logic [15:0] INT_VECTOR   = 16'h0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        stall,
  input  logic        int_req,
  input  logic [31:0] fetch_pc,
  output logic        pc_enable,
  output logic        pc_write,
  output logic [15:0] pc_write_back_value,
  output logic        clear_instruction,
  output logic        int_ack,
  output logic [31:0] int_return_pc,
  output logic        busy
);

  localparam int          CNT_W      = 3;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_RUN      = 3'd1,
    S_FLUSH    = 3'd2,
    S_INT_SAVE = 3'd3,
    S_INT_JUMP = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_BOOT;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

`ifdef FETCH_CTRL_INT_EN
  logic [31:0] ret_pc, ret_pc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_pc <= '0;
    end else begin
      ret_pc <= ret_pc_next;
    end
  end

  assign int_return_pc = ret_pc;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{int_req, fetch_pc};
  assign int_return_pc     = '0;
`endif

  always_comb begin
    state_next          = state;
    flush_cnt_next      = flush_cnt;
    pc_enable           = 1'b0;
    pc_write            = 1'b0;
    pc_write_back_value = '0;
    clear_instruction   = 1'b0;
    int_ack             = 1'b0;
    busy                = (state != S_RUN);
`ifdef FETCH_CTRL_INT_EN
    ret_pc_next         = ret_pc;
`endif

    case (state)
      S_BOOT: begin
        pc_write            = 1'b1;
        pc_write_back_value = RESET_VECTOR;
        pc_enable           = 1'b1;
        clear_instruction   = 1'b1;
        state_next          = S_RUN;
      end

      // RUN and FLUSH share the redirect path; a redirect in FLUSH restarts the window.
      S_RUN, S_FLUSH: begin
        pc_enable         = 1'b1;
        clear_instruction = (state == S_FLUSH);
        if (redirect_valid) begin
          pc_write            = 1'b1;
          pc_write_back_value = redirect_target;
          clear_instruction   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_next = FLUSH_LOAD;
            state_next     = S_FLUSH;
          end else begin
            state_next     = S_RUN;
          end
        end else if (state == S_FLUSH) begin
          if (flush_cnt <= CNT_W'(1)) begin
            flush_cnt_next = '0;
            state_next     = S_RUN;
          end else begin
            flush_cnt_next = flush_cnt - CNT_W'(1);
          end
        end
`ifdef FETCH_CTRL_INT_EN
        else if (int_req) begin
          pc_enable         = 1'b0;
          clear_instruction = 1'b1;
          int_ack           = 1'b1;
          ret_pc_next       = fetch_pc;
          state_next        = S_INT_SAVE;
        end
`endif
        else if (stall) begin
          pc_enable = 1'b0;
        end
      end

`ifdef FETCH_CTRL_INT_EN
      // An older branch resolving during entry becomes the return address.
      S_INT_SAVE: begin
        clear_instruction = 1'b1;
        if (redirect_valid) ret_pc_next = {16'h0000, redirect_target};
        state_next = S_INT_JUMP;
      end

      S_INT_JUMP: begin
        pc_write            = 1'b1;
        pc_write_back_value = INT_VECTOR;
        pc_enable           = 1'b1;
        clear_instruction   = 1'b1;
        if (redirect_valid) ret_pc_next = {16'h0000, redirect_target};
        state_next = S_RUN;
      end
`endif

      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_control_unit.sv
// Table-driven bench for fetch_control_unit (FLUSH_CYCLES=3); follows FETCH_CTRL_INT_EN.
`default_nettype none

module tb_fetch_control_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        stall;
  logic        int_req;
  logic [31:0] fetch_pc;
  logic        pc_enable;
  logic        pc_write;
  logic [15:0] pc_write_back_value;
  logic        clear_instruction;
  logic        int_ack;
  logic [31:0] int_return_pc;
  logic        busy;

  fetch_control_unit #(
    .RESET_VECTOR (16'h0020),
    .INT_VECTOR   (16'h0000),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .stall               (stall),
    .int_req             (int_req),
    .fetch_pc            (fetch_pc),
    .pc_enable           (pc_enable),
    .pc_write            (pc_write),
    .pc_write_back_value (pc_write_back_value),
    .clear_instruction   (clear_instruction),
    .int_ack             (int_ack),
    .int_return_pc       (int_return_pc),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [15:0] tgt;
    logic        st;
    logic        ir;
    logic [31:0] fpc;
    logic        en;
    logic        wr;
    logic [15:0] val;
    logic        clr;
    logic        ack;
    logic        bsy;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic v(input logic rst_n, input logic rv, input logic [15:0] tgt,
                   input logic st, input logic ir, input logic [31:0] fpc,
                   input logic en, input logic wr, input logic [15:0] val,
                   input logic clr, input logic ack, input logic bsy,
                   input logic [31:0] ret);
    vec_t t;
    t.rst_n = rst_n; t.rv = rv; t.tgt = tgt; t.st = st; t.ir = ir; t.fpc = fpc;
    t.en = en; t.wr = wr; t.val = val; t.clr = clr; t.ack = ack; t.bsy = bsy; t.ret = ret;
    vecs.push_back(t);
  endtask

  task automatic check_cnt(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    logic [20:0] got_o, exp_o;
    int clr_cnt, wr_cnt, en_cnt;

    reset = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    stall = 1'b0; int_req = 1'b0; fetch_pc = '0;

    //  rst rv tgt       st ir fpc           en wr val       clr ack bsy ret
    v(0, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // 0 reset
    v(0, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);
    v(0, 1, 16'h0011, 1, 1, 32'h5,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // inputs ignored
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // BOOT
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);   // RUN
    v(1, 1, 16'h0045, 0, 0, 32'h0,        1, 1, 16'h0045, 1, 0, 0, 32'h0);   // 5 redirect
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);   // FLUSH
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);   // FLUSH
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);   // RUN
    v(1, 1, 16'h0077, 1, 0, 32'h0,        1, 1, 16'h0077, 1, 0, 0, 32'h0);   // stall+redirect
    v(1, 0, 16'h0000, 1, 1, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);   // 10 FLUSH ignores
    v(1, 1, 16'h0099, 0, 0, 32'h0,        1, 1, 16'h0099, 1, 0, 1, 32'h0);   // redirect in FLUSH
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);
    v(1, 0, 16'h0000, 1, 0, 32'h0,        0, 0, 16'h0000, 0, 0, 0, 32'h0);   // stall
    v(1, 0, 16'h0000, 1, 0, 32'h0,        0, 0, 16'h0000, 0, 0, 0, 32'h0);   // 15 stall
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
`ifdef FETCH_CTRL_INT_EN
    v(1, 0, 16'h0000, 0, 1, 32'h31,       0, 0, 16'h0000, 1, 1, 0, 32'h0);   // accept
    v(1, 0, 16'h0000, 0, 0, 32'h99,       0, 0, 16'h0000, 1, 0, 1, 32'h31);  // INT_SAVE
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0000, 1, 0, 1, 32'h31);  // INT_JUMP
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h31);  // 20 RUN
    v(1, 0, 16'h0000, 0, 1, 32'h40,       0, 0, 16'h0000, 1, 1, 0, 32'h31);
    v(1, 1, 16'h0050, 0, 0, 32'h0,        0, 0, 16'h0000, 1, 0, 1, 32'h40);  // redirect in SAVE
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0000, 1, 0, 1, 32'h50);
    v(1, 1, 16'h0060, 0, 1, 32'h0,        1, 1, 16'h0060, 1, 0, 0, 32'h50);  // redirect beats int
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h50);  // 25
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h50);
    v(1, 0, 16'h0000, 0, 1, 32'h70,       0, 0, 16'h0000, 1, 1, 0, 32'h50);
    v(1, 0, 16'h0000, 0, 1, 32'h71,       0, 0, 16'h0000, 1, 0, 1, 32'h70);
    v(0, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // reset in INT_JUMP
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // 30 BOOT
    v(1, 0, 16'h0000, 0, 1, 32'h80,       0, 0, 16'h0000, 1, 1, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h0,        0, 0, 16'h0000, 1, 0, 1, 32'h80);
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 1, 16'h0000, 1, 0, 1, 32'h80);
    v(1, 0, 16'h0000, 0, 1, 32'h81,       0, 0, 16'h0000, 1, 1, 0, 32'h80);  // re-accepted
    v(1, 0, 16'h0000, 0, 0, 32'h0,        0, 0, 16'h0000, 1, 0, 1, 32'h81);  // 35
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0000, 1, 0, 1, 32'h81);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h81);
`else
    v(1, 0, 16'h0000, 0, 1, 32'h31,       1, 0, 16'h0000, 0, 0, 0, 32'h0);   // int ignored
    v(1, 0, 16'h0000, 0, 0, 32'h99,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);   // 20
    v(1, 0, 16'h0000, 0, 1, 32'h40,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 1, 16'h0050, 0, 0, 32'h0,        1, 1, 16'h0050, 1, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);
    v(1, 1, 16'h0060, 0, 1, 32'h0,        1, 1, 16'h0060, 1, 0, 1, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);   // 25
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 1, 0, 1, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h70,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h71,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(0, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // reset
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 1, 16'h0020, 1, 0, 1, 32'h0);   // 30 BOOT
    v(1, 0, 16'h0000, 0, 1, 32'h80,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 1, 32'h81,       1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);   // 35
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
    v(1, 0, 16'h0000, 0, 0, 32'h0,        1, 0, 16'h0000, 0, 0, 0, 32'h0);
`endif

    // Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      reset           = vecs[i].rst_n;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      stall           = vecs[i].st;
      int_req         = vecs[i].ir;
      fetch_pc        = vecs[i].fpc;
      #4;
      got_o = {pc_enable, pc_write, pc_write_back_value, clear_instruction, int_ack, busy};
      exp_o = {vecs[i].en, vecs[i].wr, vecs[i].val, vecs[i].clr, vecs[i].ack, vecs[i].bsy};
      n_vec++;
      if (got_o !== exp_o || int_return_pc !== vecs[i].ret) begin
        n_bad++;
        $display("FAIL vec%0d: got en/wr/val/clr/ack/busy=%h ret=%h, expected %h ret=%h",
                 i, got_o, int_return_pc, exp_o, vecs[i].ret);
      end
      @(posedge clk);
      #1;
    end

    // Redirect under a held stall: one PC load, three NOP cycles, stall only after the flush.
    clr_cnt = 0; wr_cnt = 0; en_cnt = 0;
    stall = 1'b1; int_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      redirect_valid  = (c == 0);
      redirect_target = 16'h0123;
      #4;
      if (clear_instruction === 1'b1) clr_cnt++;
      if (pc_write === 1'b1) wr_cnt++;
      if (pc_enable === 1'b1) en_cnt++;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    check_cnt("flush_clear_cycles", clr_cnt, 3);
    check_cnt("flush_pc_writes", wr_cnt, 1);
    check_cnt("flush_enable_cycles", en_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_control_unit.md
# fetch_control_unit

Sequencer for the fetch stage's PC control inputs. It generates `pc_enable`, `pc_write`, `pc_write_back_value` and `clear_instruction` from the pipeline's redirect, stall and interrupt requests. It sits between the hazard/branch logic in decode/execute and the fetch stage. It owns the boot sequence, flush windows and the interrupt entry sequence.

## Interface
Parameters:
- `RESET_VECTOR`, 16'h0020: PC loaded after reset (first instruction-memory address).
- `INT_VECTOR`, 16'h0000: PC loaded on interrupt entry.
- `FLUSH_CYCLES`, 1: cycles `clear_instruction` is held per redirect, including the redirect cycle; legal range 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  taken branch/jump/return from a later stage.
- `redirect_target`  in  16  new PC for the redirect.
- `stall`  in  1  load-use or structural stall; hold PC.
- `int_req`  in  1  level interrupt request.
- `fetch_pc`  in  32  current PC+1 from the fetch stage (`pc_plus_one_r`).
- `pc_enable`  out  1  PC advance enable.
- `pc_write`  out  1  PC load strobe.
- `pc_write_back_value`  out  16  value loaded when `pc_write`=1.
- `clear_instruction`  out  1  replace the fetched instruction with NOP.
- `int_ack`  out  1  one-cycle pulse when an interrupt is accepted.
- `int_return_pc`  out  32  latched return address for the interrupt.
- `busy`  out  1  high in every state except RUN.

## Operation
- States: BOOT, RUN, FLUSH, INT_SAVE, INT_JUMP.
- Outputs are combinational (Mealy) from state and inputs. State, flush counter and `int_return_pc` are registered.
- **BOOT:**
  - Drives `pc_write`=1, `pc_write_back_value`=RESET_VECTOR, `pc_enable`=1, `clear_instruction`=1.
  - Always moves to RUN on the next cycle. All inputs are ignored.
- **RUN:** requests are handled in priority order, highest first.
  - `redirect_valid`:
    - Drives `pc_write`=1, value=`redirect_target`, `pc_enable`=1, `clear_instruction`=1.
    - If FLUSH_CYCLES>1, loads the counter with FLUSH_CYCLES-1 and goes to FLUSH; otherwise stays in RUN.
  - `int_req` (macro enabled):
    - Drives `pc_enable`=0, `clear_instruction`=1, `int_ack`=1.
    - Latches `int_return_pc`<=`fetch_pc` and goes to INT_SAVE.
  - `stall`: drives `pc_enable`=0 and nothing else; the stage re-fetches the same PC.
  - No request: `pc_enable`=1, all other outputs 0.
- **FLUSH:**
  - Drives `pc_enable`=1, `clear_instruction`=1.
  - Decrements the counter and returns to RUN when the counter reaches 0.
  - A new `redirect_valid` restarts the sequence exactly as in RUN. `stall` and `int_req` are ignored.
- **INT_SAVE:**
  - Drives `pc_enable`=0, `clear_instruction`=1, then goes to INT_JUMP.
  - `redirect_valid` here (an older branch resolving) overwrites `int_return_pc` with {16'h0, `redirect_target`}. No PC write occurs.
- **INT_JUMP:**
  - Drives `pc_write`=1, value=INT_VECTOR, `pc_enable`=1, `clear_instruction`=1, then goes to RUN.
  - `redirect_valid` is handled as in INT_SAVE.
- `int_req` still high on return to RUN is accepted again. Software/ISR deasserts it.
- `stall` never blocks an interrupt sequence or a flush.

## Timing
- Reset asserted (low):
  - State goes to BOOT immediately, flush counter 0, `int_return_pc`=0.
  - Outputs while in reset: `pc_write`=1, value=RESET_VECTOR, `pc_enable`=1, `clear_instruction`=1, `int_ack`=0, `busy`=1.
- First rising edge after reset deassertion: leaves BOOT. `busy`=0 from the next cycle.
- Redirect-to-PC-load latency: 0 cycles (same cycle). The new PC is visible at fetch after the next edge.
- Interrupt entry:
  - Cycle 0: accept and `int_ack` pulse (RUN).
  - Cycle 1: INT_SAVE.
  - Cycle 2: INT_JUMP, PC load.
  - Cycle 3: back in RUN.
- Reset mid-sequence (FLUSH or INT_*) aborts to BOOT; the latched return PC is cleared.

## Configuration
- `FETCH_CTRL_INT_EN` defined: interrupt states, `int_ack` and `int_return_pc` are functional.
- `FETCH_CTRL_INT_EN` undefined:
  - `int_req` is ignored.
  - `int_ack` and `int_return_pc` are tied to 0.
  - INT_SAVE/INT_JUMP are not synthesized.

## Test plan
- Reset low for 3 cycles, release → one BOOT cycle with `pc_write`=1, value 16'h0020, `clear_instruction`=1; then RUN with `pc_enable`=1 and `busy`=0.
- RUN, `redirect_valid`=1, target 16'h0045, FLUSH_CYCLES=3 → `pc_write` for 1 cycle with value 16'h0045; `clear_instruction` high for exactly 3 cycles.
- `stall`=1 together with `redirect_valid`=1 → redirect wins (`pc_write`=1, `pc_enable`=1). `stall` alone for 2 cycles → `pc_enable`=0 for 2 cycles, no clear.
- `int_req`=1 with `fetch_pc`=32'h0000_0031 → `int_ack` pulse; `int_return_pc`=32'h31; INT_VECTOR loaded 2 cycles later; RUN on cycle 3.
- Redirect to 16'h0050 during INT_SAVE → `int_return_pc`=32'h50; no PC write until INT_JUMP loads INT_VECTOR.
- Reset pulsed during INT_JUMP → BOOT immediately; `int_return_pc`=0; RESET_VECTOR loaded.
